// File: rtl/game_random_arbiter.sv
// Round-robin arbiter sharing one Galois LFSR among N_REQ requesters; each grant
// carries the pre-step LFSR value. Optional seed port under `GAME_RANDOM_SEED_EN.
module game_random_arbiter #(
  parameter int               N_REQ      = 4,
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 16'h100B,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'h1FFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] random
`ifdef GAME_RANDOM_SEED_EN
  ,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr, lfsr_shift, lfsr_next;
  logic [PTR_W-1:0] rr_ptr, pick, cand, ptr_next;
  logic [N_REQ-1:0] pick_oh;
  logic             hit;

  // A zero state would lock the LFSR up, so it is replaced by the reset seed.
  always_comb begin
    lfsr_shift = {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? POLY : '0);
    lfsr_next  = (lfsr_shift == '0) ? RESET_SEED : lfsr_shift;
`ifdef GAME_RANDOM_SEED_EN
    if (seed_load) lfsr_next = (seed == '0) ? RESET_SEED : seed;
`endif
  end

  // Circular search for the first request at or after rr_ptr.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    ptr_next      = PTR_W'((int'(pick) + 1) % N_REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr   <= RESET_SEED;
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      random <= '0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE: begin
          if (hit) begin
            random <= lfsr;
            gnt    <= pick_oh;
            rr_ptr <= ptr_next;
            state  <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_random_arbiter.sv
// Directed checks of grant order, LFSR values, reset behaviour and (when
// GAME_RANDOM_SEED_EN is defined) seed loading for game_random_arbiter.
module tb_game_random_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [15:0] random;
`ifdef GAME_RANDOM_SEED_EN
  logic        seed_load;
  logic [15:0] seed;
`endif

  int vectors = 0;
  int miscompares = 0;

  game_random_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .random (random)
`ifdef GAME_RANDOM_SEED_EN
    ,
    .seed_load (seed_load),
    .seed      (seed)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [3:0]  exp_g [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
  logic [15:0] exp_r [10] = '{16'h1FFF, 16'h1FFF, 16'h7FFC, 16'h7FFC, 16'hEFFB,
                              16'hEFFB, 16'h8FF1, 16'h8FF1, 16'h1FD2, 16'h1FD2};

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
`ifdef GAME_RANDOM_SEED_EN
    seed_load = 1'b0;
    seed      = 16'h0000;
`endif
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_random", 32'(random), 32'h0);

    // Single requester held from reset release
    reset = 1'b1;
    req   = 4'b0001;
    tick(); chk("t1_gnt_e1", 32'(gnt), 32'h1);  chk("t1_rand_e1", 32'(random), 32'h1FFF);
    tick(); chk("t1_gnt_e2", 32'(gnt), 32'h0);  chk("t1_hold_e2", 32'(random), 32'h1FFF);
    tick(); chk("t1_gnt_e3", 32'(gnt), 32'h1);  chk("t1_rand_e3", 32'(random), 32'h7FFC);
    req = 4'b0000;
    tick(); chk("t1_gnt_e4", 32'(gnt), 32'h0);  chk("t1_hold_e4", 32'(random), 32'h7FFC);

    // Free-running LFSR: grant at edge 5 returns the 4th step
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    chk("t2_idle_gnt", 32'(gnt), 32'h0);
    req = 4'b0001;
    tick(); chk("t2_gnt_e5", 32'(gnt), 32'h1);  chk("t2_rand_e5", 32'(random), 32'hEFFB);

    // Async reset in the middle of GRANT
    reset = 1'b0;
    #1;
    chk("t5_gnt_async", 32'(gnt), 32'h0);
    chk("t5_rand_async", 32'(random), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(); chk("t5_gnt_after", 32'(gnt), 32'h1); chk("t5_rand_after", 32'(random), 32'h1FFF);
    req = 4'b0000;
    tick();

    // All four requesting: round-robin, one grant every 2 cycles
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_gnt_%0d", i), 32'(gnt), 32'(exp_g[i]));
      chk($sformatf("t3_rand_%0d", i), 32'(random), 32'(exp_r[i]));
    end

    // rr_ptr=1 with req=0101: requester 2 first; GRANT-cycle req ignored
    req = 4'b0101;
    tick(); chk("t4_gnt_first", 32'(gnt), 32'h4); chk("t4_rand_first", 32'(random), 32'h7F48);
    req = 4'b1010;
    tick(); chk("t4_gnt_ignore", 32'(gnt), 32'h0); chk("t4_hold", 32'(random), 32'h7F48);
    req = 4'b0001;
    tick(); chk("t4_gnt_second", 32'(gnt), 32'h1); chk("t4_rand_second", 32'(random), 32'hED2B);
    req = 4'b0000;
    tick(); chk("t4_gnt_end", 32'(gnt), 32'h0);

`ifdef GAME_RANDOM_SEED_EN
    // Zero seed maps to RESET_SEED; load overrides that edge's step
    reset = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    seed_load = 1'b1;
    seed      = 16'h0000;
    tick();
    seed_load = 1'b0;
    req       = 4'b0001;
    tick(); chk("t6_zero_seed", 32'(random), 32'h1FFF);
    req = 4'b0000;
    tick();
    // Grant on the load edge sees the pre-load value
    req       = 4'b0001;
    seed_load = 1'b1;
    seed      = 16'hABCD;
    tick(); chk("t6_gnt_load", 32'(gnt), 32'h1); chk("t6_rand_preload", 32'(random), 32'h7FFC);
    seed_load = 1'b0;
    tick();
    tick(); chk("t6_rand_postload", 32'(random), 32'h4791);
    req = 4'b0000;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
